// File: rtl/ch_pkg.sv
// Shared types and constants for the choose-driven round engine.
package ch_pkg;

  localparam int WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Top bytes of the SHA-256 round constants K[0..15].
  localparam logic [WIDTH-1:0] K [16] = '{
    8'h42, 8'h71, 8'hB5, 8'hE9, 8'h39, 8'h59, 8'h92, 8'hAB,
    8'hD8, 8'h12, 8'h24, 8'h55, 8'h72, 8'h80, 8'h9B, 8'hC1
  };

  function automatic logic [WIDTH-1:0] k_of(input logic [3:0] idx);
    return K[idx];
  endfunction

endpackage

// File: rtl/choose.sv
// Bitwise choose: each bit of a selects b (a=1) or c (a=0).
module choose #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] chosen
);

  assign chosen = (a & b) | (~a & c);

endmodule

// File: rtl/ch_round_engine.sv
// Round engine: holds e/f/g/h, runs ROUNDS choose-based rounds per job, one word per round.
module ch_round_engine
  import ch_pkg::*;
#(
  parameter int ROUNDS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] init_e,
  input  logic [WIDTH-1:0] init_f,
  input  logic [WIDTH-1:0] init_g,
  input  logic [WIDTH-1:0] init_h,
  input  logic [WIDTH-1:0] w_in,
  input  logic             w_valid,
  output logic             w_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] e_out,
  output logic [WIDTH-1:0] f_out,
  output logic [WIDTH-1:0] g_out,
  output logic [WIDTH-1:0] h_out,
  output state_t           state,
  output logic [3:0]       rnd
);

  // Handshake: a word is consumed on any rising edge where w_valid and w_ready
  // are both high; w_ready is high exactly while in RUN and w_in must be stable
  // while w_valid is high. Dropping w_valid stalls everything indefinitely.

  localparam logic [3:0] LAST = 4'(ROUNDS - 1);

  logic [WIDTH-1:0] chosen;
  logic [WIDTH-1:0] t1;

  choose #(.W(WIDTH)) u_choose (
    .a      (e_out),
    .b      (f_out),
    .c      (g_out),
    .chosen (chosen)
  );

  // Single-cycle round: all additions wrap at 8 bits.
  assign t1 = h_out + chosen + k_of(rnd) + w_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      e_out   <= '0;
      f_out   <= '0;
      g_out   <= '0;
      h_out   <= '0;
      rnd     <= '0;
      w_ready <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            e_out   <= init_e;
            f_out   <= init_f;
            g_out   <= init_g;
            h_out   <= init_h;
            rnd     <= '0;
            w_ready <= 1'b1;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (w_valid && w_ready) begin
            h_out <= g_out;
            g_out <= f_out;
            f_out <= e_out;
            e_out <= t1;
            rnd   <= rnd + 4'd1;
            if (rnd == LAST) begin
              w_ready <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          w_ready <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ch_round_engine.sv
// Directed bench for ch_round_engine: one ROUNDS=1 and one ROUNDS=8 instance.
module tb_ch_round_engine;
  import ch_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start1, w_valid1, w_ready1, busy1, done1;
  logic [7:0] init_e1, init_f1, init_g1, init_h1, w_in1;
  logic [7:0] e_out1, f_out1, g_out1, h_out1;
  state_t     state1;
  logic [3:0] rnd1;

  logic       start8, w_valid8, w_ready8, busy8, done8;
  logic [7:0] init_e8, init_f8, init_g8, init_h8, w_in8;
  logic [7:0] e_out8, f_out8, g_out8, h_out8;
  state_t     state8;
  logic [3:0] rnd8;

  ch_round_engine #(.ROUNDS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .init_e(init_e1), .init_f(init_f1), .init_g(init_g1), .init_h(init_h1),
    .w_in(w_in1), .w_valid(w_valid1), .w_ready(w_ready1),
    .busy(busy1), .done(done1),
    .e_out(e_out1), .f_out(f_out1), .g_out(g_out1), .h_out(h_out1),
    .state(state1), .rnd(rnd1)
  );

  ch_round_engine #(.ROUNDS(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8),
    .init_e(init_e8), .init_f(init_f8), .init_g(init_g8), .init_h(init_h8),
    .w_in(w_in8), .w_valid(w_valid8), .w_ready(w_ready8),
    .busy(busy8), .done(done8),
    .e_out(e_out8), .f_out(f_out8), .g_out(g_out8), .h_out(h_out8),
    .state(state8), .rnd(rnd8)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] kt [16];
  logic [7:0] words [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference rounds: bit-select form of choose, 8-bit wrapping sums.
  function automatic logic [31:0] model(input logic [31:0] init, input int n);
    logic [7:0] e, f, g, h, ch, t;
    {e, f, g, h} = init;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) ch[b] = e[b] ? f[b] : g[b];
      t = h + ch + kt[i] + words[i];
      h = g; g = f; f = e; e = t;
    end
    return {e, f, g, h};
  endfunction

  task automatic job1(input string tag, input logic [31:0] init, input logic [7:0] w,
                      input logic [31:0] exp);
    @(posedge clk); #1;
    start1 = 1'b1; {init_e1, init_f1, init_g1, init_h1} = init;
    w_in1 = w; w_valid1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    check({tag, "_run_flags"}, {29'd0, busy1, w_ready1, done1}, 32'b110);
    check({tag, "_loaded"}, {e_out1, f_out1, g_out1, h_out1}, init);
    @(posedge clk); #1;
    check({tag, "_done_flags"}, {29'd0, busy1, w_ready1, done1}, 32'b101);
    check({tag, "_result"}, {e_out1, f_out1, g_out1, h_out1}, exp);
    w_valid1 = 1'b0;
    @(posedge clk); #1;
    check({tag, "_idle_flags"}, {29'd0, busy1, w_ready1, done1}, 32'b000);
    check({tag, "_held"}, {e_out1, f_out1, g_out1, h_out1}, exp);
  endtask

  task automatic job8(input string tag, input logic [31:0] init, input int stall_after,
                      input int stall_len, input bit poke_start);
    int k, st, lat;
    bit hs, stalled;
    logic [31:0] snap;
    @(posedge clk); #1;
    start8 = 1'b1; {init_e8, init_f8, init_g8, init_h8} = init;
    k = 0; st = 0; lat = 0;
    w_in8 = words[0]; w_valid8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    check({tag, "_run_state"}, 32'(state8), 32'(RUN));
    while (lat < 40) begin
      stalled = 1'b0;
      if (k == stall_after && st < stall_len) begin
        w_valid8 = 1'b0; st++; stalled = 1'b1;
        snap = {e_out8, f_out8, g_out8, h_out8};
      end else begin
        w_valid8 = 1'b1;
      end
      if (poke_start && lat == 3) begin
        start8 = 1'b1; {init_e8, init_f8, init_g8, init_h8} = ~init;
      end else begin
        start8 = 1'b0;
      end
      hs = w_valid8 && w_ready8;
      @(posedge clk); #1;
      lat++;
      if (hs) begin
        k++;
        if (k < 16) w_in8 = words[k];
      end
      if (stalled) begin
        check({tag, "_stall_rnd"}, 32'(rnd8), 32'(k));
        check({tag, "_stall_regs"}, {e_out8, f_out8, g_out8, h_out8}, snap);
      end
      if (done8) break;
    end
    start8 = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(8 + stall_len));
    check({tag, "_done_flags"}, {29'd0, busy8, w_ready8, done8}, 32'b101);
    check({tag, "_result"}, {e_out8, f_out8, g_out8, h_out8}, model(init, 8));
    w_valid8 = 1'b0;
    @(posedge clk); #1;
    check({tag, "_idle_flags"}, {29'd0, busy8, w_ready8, done8}, 32'b000);
    check({tag, "_idle_state"}, 32'(state8), 32'(IDLE));
  endtask

  initial begin
    kt = '{8'h42, 8'h71, 8'hB5, 8'hE9, 8'h39, 8'h59, 8'h92, 8'hAB,
           8'hD8, 8'h12, 8'h24, 8'h55, 8'h72, 8'h80, 8'h9B, 8'hC1};
    for (int i = 0; i < 16; i++) words[i] = 8'(i * 37 + 5);

    rst = 1'b1;
    start1 = 0; w_valid1 = 0; w_in1 = 0; {init_e1, init_f1, init_g1, init_h1} = '0;
    start8 = 0; w_valid8 = 0; w_in8 = 0; {init_e8, init_f8, init_g8, init_h8} = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst1_flags", {29'd0, busy1, w_ready1, done1}, 32'b000);
    check("rst8_regs", {e_out8, f_out8, g_out8, h_out8}, 32'h0);
    check("rst8_state", 32'(state8), 32'(IDLE));
    check("rst8_rnd", 32'(rnd8), 32'd0);
    rst = 1'b0;

    job1("t1", 32'h0C0E0800, 8'h00, 32'h4E0C0E08);
    job1("t3", 32'h00066400, 8'h00, 32'hA6000664);

    // Wrap case, with start held through the DONE cycle into IDLE.
    @(posedge clk); #1;
    start1 = 1'b1; {init_e1, init_f1, init_g1, init_h1} = 32'hFF00FFFF;
    w_in1 = 8'h01; w_valid1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    @(posedge clk); #1;
    check("t2_done", {31'd0, done1}, 32'd1);
    check("t2_result", {e_out1, f_out1, g_out1, h_out1}, 32'h42FF00FF);
    start1 = 1'b1; {init_e1, init_f1, init_g1, init_h1} = 32'h00066400; w_in1 = 8'h00;
    @(posedge clk); #1;
    check("poke_done_flags", {29'd0, busy1, w_ready1, done1}, 32'b000);
    check("poke_done_regs", {e_out1, f_out1, g_out1, h_out1}, 32'h42FF00FF);
    @(posedge clk); #1;
    start1 = 1'b0;
    check("poke_idle_accept", {29'd0, busy1, w_ready1, done1}, 32'b110);
    check("poke_idle_load", {e_out1, f_out1, g_out1, h_out1}, 32'h00066400);
    @(posedge clk); #1;
    check("poke_job_result", {e_out1, f_out1, g_out1, h_out1}, 32'hA6000664);
    w_valid1 = 1'b0;
    @(posedge clk); #1;

    job8("r8_plain", 32'h01020304, -1, 0, 1'b0);
    job8("r8_stall", 32'h01020304, 2, 3, 1'b0);
    job8("r8_poke", 32'h01020304, -1, 0, 1'b1);

    // Reset asserted while round 4 is pending.
    @(posedge clk); #1;
    start8 = 1'b1; {init_e8, init_f8, init_g8, init_h8} = 32'h11223344;
    w_in8 = words[0]; w_valid8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      w_in8 = words[i + 1];
    end
    check("pre_rst_rnd", 32'(rnd8), 32'd3);
    rst = 1'b1;
    #1;
    check("abort_flags", {29'd0, busy8, w_ready8, done8}, 32'b000);
    check("abort_regs", {e_out8, f_out8, g_out8, h_out8}, 32'h0);
    check("abort_state", 32'(state8), 32'(IDLE));
    check("abort_rnd", 32'(rnd8), 32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("abort_stays_idle", 32'(state8), 32'(IDLE));
    w_valid8 = 1'b0;

    job8("r8_after_rst", 32'hA5C37E19, -1, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
